// File: rtl/soc_irq_ctrl.sv
// soc_irq_ctrl: Avalon-MM interrupt controller with per-source level/edge latching,
// masking, fixed lowest-index priority and a single registered CPU interrupt.
// Optional build macro IRQ_CTRL_SYNC_EN inserts a 2-flop synchronizer on irq_in.
module soc_irq_ctrl #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq
);

    localparam int unsigned DW   = 16;
    localparam int unsigned IDXW = 4;

    localparam logic [2:0] A_PENDING = 3'd0;
    localparam logic [2:0] A_MASK    = 3'd1;
    localparam logic [2:0] A_MODE    = 3'd2;
    localparam logic [2:0] A_ACTIVE  = 3'd3;
    localparam logic [2:0] A_RAW     = 3'd4;
    localparam logic [2:0] A_FORCE   = 3'd5;

    logic [NUM_IRQ-1:0] s_d;
    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] prev;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] mode;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] wdata;
    logic [NUM_IRQ-1:0] w1c_clr;
    logic [NUM_IRQ-1:0] force_set;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] rise;
    logic               wr;
    logic               valid;
    logic [IDXW-1:0]    idx;
    logic [DW-1:0]      rd_mux;

    // Upper writedata bits beyond NUM_IRQ are don't-care for every register.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

`ifdef IRQ_CTRL_SYNC_EN
    logic [NUM_IRQ-1:0] sync_q1;
    logic [NUM_IRQ-1:0] sync_q2;

    // Two-flop synchronizer for asynchronous peripheral lines.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_in;
            sync_q2 <= sync_q1;
        end
    end

    assign s_d = sync_q2;
`else
    assign s_d = irq_in;
`endif

    // Bus decode, priority encode and pending next-state.
    always_comb begin
        wr        = chipselect & ~write_n;
        wdata     = writedata[NUM_IRQ-1:0];
        w1c_clr   = '0;
        force_set = '0;
        ack_clr   = '0;
        active    = pending & mask;
        valid     = |active;
        idx       = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (active[i]) idx = IDXW'(i);
        end
        if (wr && address == A_PENDING) w1c_clr   = wdata & mode;
        if (wr && address == A_FORCE)   force_set = wdata & mode;
        if (wr && address == A_ACTIVE && valid) ack_clr = (NUM_IRQ'(1) << idx) & mode;
        rise        = s & ~prev;
        // Set terms are OR'd after the clear so a same-cycle event is never lost.
        pending_nxt = (mode & ((pending & ~(w1c_clr | ack_clr)) | rise | force_set))
                    | (~mode & s);
    end

    // Read address mux; readdata registers it every cycle.
    always_comb begin
        rd_mux = '0;
        case (address)
            A_PENDING: rd_mux = DW'(pending);
            A_MASK:    rd_mux = DW'(mask);
            A_MODE:    rd_mux = DW'(mode);
            A_ACTIVE:  rd_mux = {valid, 11'b0, idx};
            A_RAW:     rd_mux = DW'(s);
            default:   rd_mux = '0;
        endcase
    end

    // Sampling, control registers, pending state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s        <= '0;
            prev     <= '0;
            pending  <= '0;
            mask     <= '0;
            mode     <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            s        <= s_d;
            prev     <= s;
            pending  <= pending_nxt;
            if (wr && address == A_MASK) mask <= wdata;
            if (wr && address == A_MODE) mode <= wdata;
            readdata <= rd_mux;
            irq      <= valid;
        end
    end

endmodule
